pot_adc_scheduler: RTL and testbench
====================================

Name: pot_adc_scheduler

Overview:
- Time-shares one external 8-bit parallel ADC, e.g. an ADC0804-class part with active-low start, done and read pins, between the two player potentiometers of the Pong design.
- Drives an analog mux select, sequences settle, start, convert and read, and publishes one registered 8-bit value per player with a one-cycle valid strobe.
- Sits between the JPorts ADC pins and the paddle-position logic.

Parameters:
- SETTLE_CYCLES, 100: cycles to wait after a mux_sel change before starting a conversion (min 1).
- START_CYCLES, 4: width of the adc_start_n low pulse, in cycles (min 1).
- CONV_TIMEOUT, 1000: maximum cycles to wait in CONVERT for a synchronised done (min 1).
- READ_CYCLES, 3: adc_rd_n low time before the bus is sampled (min 1).

Ports:
- sys_clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-high reset.
- enable, input, 1: run continuous alternating conversions while high.
- adc_data, input, 8: ADC parallel data bus (JPorts).
- adc_done_n, input, 1: ADC end-of-conversion, active-low, asynchronous to sys_clk.
- adc_start_n, output, 1: ADC start-conversion, active-low.
- adc_rd_n, output, 1: ADC output-enable/read, active-low.
- mux_sel, output, 1: analog mux select; 0 = player 1, 1 = player 2.
- p1_value, output, 8: last stored player-1 value.
- p2_value, output, 8: last stored player-2 value.
- p1_valid, output, 1: one-cycle pulse when p1_value updates.
- p2_valid, output, 1: one-cycle pulse when p2_value updates.
- timeout_err, output, 1: sticky flag; set on any conversion timeout; cleared only by reset.

Behaviour:
- Reset (async assert, applied immediately mid-operation):
  - state = IDLE.
  - adc_start_n = 1, adc_rd_n = 1.
  - mux_sel = 0.
  - p1_value = p2_value = 0.
  - p1_valid = p2_valid = 0.
  - timeout_err = 0.
  - All counters = 0; synchroniser flops = 1.
- adc_done_n passes through a 2-flop synchroniser before any use. The FSM sees a falling edge 2 cycles after the pin falls.
- All outputs are registered.
- IDLE:
  - Strobes and controls are inactive.
  - If enable = 1, go to SETTLE with the counter cleared.
- SETTLE:
  - mux_sel is stable.
  - After exactly SETTLE_CYCLES cycles in this state, go to START.
- START:
  - adc_start_n = 0 for exactly START_CYCLES cycles, then go to CONVERT with the timeout counter cleared.
- CONVERT:
  - If the synchronised done = 0, go to READ. Done has priority over timeout in the same cycle.
  - Otherwise, after CONV_TIMEOUT cycles without done: set timeout_err, toggle mux_sel, and go to SETTLE if enable, else IDLE. No value or valid strobe is produced for that channel.
- READ:
  - adc_rd_n = 0 for exactly READ_CYCLES cycles.
  - adc_data is captured on the last of these cycles.
  - Then go to STORE; adc_rd_n returns high on entry to STORE.
- STORE (one cycle):
  - The registered update takes effect at the end of the cycle: the value for the channel given by current mux_sel is written, and its valid pulses for exactly one cycle, coincident with the new value.
  - In the same edge, mux_sel toggles.
  - Next state is SETTLE if enable, else IDLE.
- Channels strictly alternate 0,1,0,1,…, including after a timeout. A failed channel is not retried.
- enable falling mid-sequence: the current channel completes, through STORE or timeout, then IDLE. enable is sampled only at IDLE, STORE and timeout exits.
- p1_valid and p2_valid are never high in the same cycle.
- Nominal period per channel = SETTLE_CYCLES + START_CYCLES + t_conv + 2 (sync) + READ_CYCLES + 1.
- Counters are sized by $clog2 of the largest parameter + 1. There is no wrap inside a state.

Optional Feature:
- Macro: POT_ADC_AVERAGE_EN.
- When defined:
  - Each channel keeps a 2-sample running average.
  - Stored value = (old_value + captured + 1) >> 1, computed in 9 bits, so there is no overflow. Example: 255 + 255 + 1 = 511, >> 1 = 255.
  - The first sample after reset is stored raw, tracked by a per-channel "primed" bit cleared by reset.
- When undefined:
  - The captured byte is stored unmodified.
  - There is no averaging logic or primed bits.

Test Plan:
All scenarios use SETTLE_CYCLES = 4, START_CYCLES = 2, CONV_TIMEOUT = 16, READ_CYCLES = 2.
1. Reset and idle: reset pulse, enable = 0 -> all outputs at reset values; adc_start_n stays 1 for 100 cycles.
2. Basic alternation: enable = 1; ADC model pulls done low 5 cycles after start rises, with data 0x3C then 0xC3.
   - p1_value = 0x3C with p1_valid pulsed 1 cycle, then p2_value = 0xC3 with p2_valid pulsed.
   - mux_sel sequence is 0,1,0.
   - The low pulses of adc_start_n and adc_rd_n are 2 cycles wide.
3. Timeout: the model never asserts done on channel 0.
   - timeout_err = 1 exactly 16 cycles after entering CONVERT; no p1_valid.
   - mux_sel -> 1 and the next conversion proceeds normally.
   - timeout_err stays 1 until reset.
4. enable drop: deassert enable during CONVERT of channel 1 -> STORE completes, p2_valid pulses, then IDLE with mux_sel = 0 and no further start pulse.
5. Async reset mid-READ: assert reset while adc_rd_n = 0 -> adc_rd_n = 1 and the state is IDLE in the same cycle, without waiting for a clock edge; values cleared.
6. Averaging (POT_ADC_AVERAGE_EN): channel 0 samples 0x10 then 0x21 -> p1_value = 0x10 then 0x19. Without the macro, p1_value = 0x10 then 0x21.

Source files
------------

// File: rtl/pot_adc_scheduler_if.sv
// ADC pin bundle between pot_adc_scheduler (master) and the
// external ADC0804-class converter plus analog mux (slave).
interface pot_adc_scheduler_if;
  logic [7:0] adc_data;
  logic       adc_done_n;
  logic       adc_start_n;
  logic       adc_rd_n;
  logic       mux_sel;

  modport master (
    input  adc_data,
    input  adc_done_n,
    output adc_start_n,
    output adc_rd_n,
    output mux_sel
  );

  modport slave (
    output adc_data,
    output adc_done_n,
    input  adc_start_n,
    input  adc_rd_n,
    input  mux_sel
  );
endinterface

// File: rtl/pot_adc_scheduler.sv
// Time-shares one 8-bit parallel ADC between two paddle pots.
// Optional: POT_ADC_AVERAGE_EN enables a 2-sample running average.
module pot_adc_scheduler #(
  parameter int SETTLE_CYCLES = 100,
  parameter int START_CYCLES  = 4,
  parameter int CONV_TIMEOUT  = 1000,
  parameter int READ_CYCLES   = 3
) (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic       enable,
  pot_adc_scheduler_if.master adc,
  output logic [7:0] p1_value,
  output logic [7:0] p2_value,
  output logic       p1_valid,
  output logic       p2_valid,
  output logic       timeout_err
);

  localparam int MAX_AB = (SETTLE_CYCLES > START_CYCLES) ?
                          SETTLE_CYCLES : START_CYCLES;
  localparam int MAX_CD = (CONV_TIMEOUT > READ_CYCLES) ?
                          CONV_TIMEOUT : READ_CYCLES;
  localparam int MAXP   = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CW     = $clog2(MAXP + 1);

  localparam logic [CW-1:0] SET_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] STA_LAST = CW'(START_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(CONV_TIMEOUT - 1);
  localparam logic [CW-1:0] RD_LAST  = CW'(READ_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    START,
    CONVERT,
    READ,
    STORE
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    done_sync;
  logic          done_s;
  logic          start_n_q;
  logic          rd_n_q;
  logic          mux_q;
  logic [7:0]    cap;
  logic [7:0]    store_val;

`ifdef POT_ADC_AVERAGE_EN
  logic [1:0]    primed;
  logic [7:0]    old_val;
  logic [8:0]    avg_sum;

  // Rounded mean in 9 bits so 255+255+1 cannot overflow.
  always_comb begin
    old_val   = mux_q ? p2_value : p1_value;
    avg_sum   = {1'b0, old_val} + {1'b0, cap} + 9'd1;
    store_val = primed[mux_q] ? 8'(avg_sum >> 1) : cap;
  end
`else
  always_comb begin
    store_val = cap;
  end
`endif

  assign done_s          = done_sync[1];
  assign adc.adc_start_n = start_n_q;
  assign adc.adc_rd_n    = rd_n_q;
  assign adc.mux_sel     = mux_q;

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      done_sync   <= 2'b11;
      start_n_q   <= 1'b1;
      rd_n_q      <= 1'b1;
      mux_q       <= 1'b0;
      cap         <= '0;
      p1_value    <= '0;
      p2_value    <= '0;
      p1_valid    <= 1'b0;
      p2_valid    <= 1'b0;
      timeout_err <= 1'b0;
`ifdef POT_ADC_AVERAGE_EN
      primed      <= '0;
`endif
    end else begin
      done_sync <= {done_sync[0], adc.adc_done_n};
      p1_valid  <= 1'b0;
      p2_valid  <= 1'b0;

      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (enable) state <= SETTLE;
        end

        SETTLE: begin
          if (cnt == SET_LAST) begin
            cnt       <= '0;
            start_n_q <= 1'b0;
            state     <= START;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        START: begin
          if (cnt == STA_LAST) begin
            cnt       <= '0;
            start_n_q <= 1'b1;
            state     <= CONVERT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        CONVERT: begin
          // Done wins over a same-cycle timeout.
          if (!done_s) begin
            cnt    <= '0;
            rd_n_q <= 1'b0;
            state  <= READ;
          end else if (cnt == TMO_LAST) begin
            cnt         <= '0;
            timeout_err <= 1'b1;
            mux_q       <= ~mux_q;
            state       <= enable ? SETTLE : IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        READ: begin
          if (cnt == RD_LAST) begin
            cnt    <= '0;
            cap    <= adc.adc_data;
            rd_n_q <= 1'b1;
            state  <= STORE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        STORE: begin
          if (mux_q) begin
            p2_value <= store_val;
            p2_valid <= 1'b1;
          end else begin
            p1_value <= store_val;
            p1_valid <= 1'b1;
          end
`ifdef POT_ADC_AVERAGE_EN
          primed[mux_q] <= 1'b1;
`endif
          cnt   <= '0;
          mux_q <= ~mux_q;
          state <= enable ? SETTLE : IDLE;
        end

        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pot_adc_scheduler.sv
// Scoreboard bench for pot_adc_scheduler with a behavioural ADC model.
// Build with POT_ADC_AVERAGE_EN to check the averaging variant.
module tb_pot_adc_scheduler;

  localparam int SET = 4;
  localparam int STC = 2;
  localparam int TMO = 16;
  localparam int RDC = 2;

  logic       sys_clk = 1'b0;
  logic       reset   = 1'b1;
  logic       enable  = 1'b0;
  logic [7:0] p1_value;
  logic [7:0] p2_value;
  logic       p1_valid;
  logic       p2_valid;
  logic       timeout_err;

  pot_adc_scheduler_if bus ();

  pot_adc_scheduler #(
    .SETTLE_CYCLES(SET),
    .START_CYCLES (STC),
    .CONV_TIMEOUT (TMO),
    .READ_CYCLES  (RDC)
  ) dut (
    .sys_clk    (sys_clk),
    .reset      (reset),
    .enable     (enable),
    .adc        (bus),
    .p1_value   (p1_value),
    .p2_value   (p2_value),
    .p1_valid   (p1_valid),
    .p2_valid   (p2_valid),
    .timeout_err(timeout_err)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic       ch;
    logic [7:0] val;
  } exp_t;

  int         n_tests = 0;
  int         n_fail  = 0;
  exp_t       exp_q[$];
  logic [7:0] dq0[$];
  logic [7:0] dq1[$];
  logic       mux_log[$];
  bit         no_done0 = 1'b0;
  logic [7:0] last_v[2];
  bit         primed[2];
  int         ev[4];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  task automatic model_store(input logic ch, input logic [7:0] d,
                             output logic [7:0] v);
`ifdef POT_ADC_AVERAGE_EN
    logic [8:0] s;
    s = {1'b0, last_v[ch]} + {1'b0, d} + 9'd1;
    v = primed[ch] ? s[8:1] : d;
`else
    v = d;
`endif
    last_v[ch] = v;
    primed[ch] = 1'b1;
  endtask

  task automatic sb_check(input logic ch, input logic [7:0] val);
    exp_t e;
    if (exp_q.size() == 0) begin
      chk("sb_underflow", 32'(exp_q.size()), 1);
    end else begin
      e = exp_q.pop_front();
      chk("sb_ch", 32'(ch), 32'(e.ch));
      chk("sb_val", 32'(val), 32'(e.val));
    end
  endtask

  task automatic wait_ev(input int idx, input int target,
                         input string tag);
    int n = 0;
    while (ev[idx] < target && n < 400) begin
      @(negedge sys_clk);
      n++;
    end
    chk(tag, 32'(ev[idx] >= target), 1);
  endtask

  task automatic wait_start_high(input string tag);
    int n = 0;
    do begin
      @(negedge sys_clk);
      n++;
    end while (bus.adc_start_n == 1'b0 && n < 20);
    chk(tag, 32'(bus.adc_start_n), 1);
  endtask

  // ADC model: done falls 5 cycles after start rises, clears after read.
  initial begin : adc_model
    logic       prev;
    logic       ch;
    logic [7:0] d;
    logic [7:0] v;
    exp_t       e;
    int         n;
    bus.adc_done_n = 1'b1;
    bus.adc_data   = 8'h00;
    prev = 1'b1;
    forever begin
      @(negedge sys_clk);
      if (!reset && prev === 1'b0 && bus.adc_start_n === 1'b1) begin
        ch = bus.mux_sel;
        if (!(no_done0 && ch == 1'b0)) begin
          repeat (5) @(negedge sys_clk);
          if (!reset) begin
            if (ch) begin
              if (dq1.size() > 0) d = dq1.pop_front();
              else d = 8'hA6;
            end else begin
              if (dq0.size() > 0) d = dq0.pop_front();
              else d = 8'h55;
            end
            model_store(ch, d, v);
            e.ch  = ch;
            e.val = v;
            exp_q.push_back(e);
            bus.adc_data   = d;
            bus.adc_done_n = 1'b0;
            n = 0;
            while (bus.adc_rd_n !== 1'b0 && !reset && n < 100) begin
              @(negedge sys_clk);
              n++;
            end
            if (n >= 100) chk("model_rd_wait", 32'(n), 0);
            n = 0;
            while (bus.adc_rd_n !== 1'b1 && n < 100) begin
              @(negedge sys_clk);
              n++;
            end
            if (n >= 100) chk("model_rd_release", 32'(n), 0);
            bus.adc_done_n = 1'b1;
          end
        end
      end
      prev = bus.adc_start_n;
    end
  end

  initial begin : reset_clear
    forever begin
      @(posedge reset);
      exp_q.delete();
      primed[0] = 1'b0;
      primed[1] = 1'b0;
      last_v[0] = 8'h00;
      last_v[1] = 8'h00;
    end
  end

  initial begin : monitor
    int   st_w;
    int   rd_w;
    logic prev_st;
    logic prev_rd;
    st_w = 0;
    rd_w = 0;
    prev_st = 1'b1;
    prev_rd = 1'b1;
    forever begin
      @(negedge sys_clk);
      if (reset) begin
        st_w = 0;
        rd_w = 0;
      end else begin
        if (bus.adc_start_n == 1'b0) st_w++;
        else if (st_w != 0) begin
          chk("start_width", 32'(st_w), STC);
          st_w = 0;
        end
        if (bus.adc_rd_n == 1'b0) rd_w++;
        else if (rd_w != 0) begin
          chk("rd_width", 32'(rd_w), RDC);
          rd_w = 0;
        end
        if (prev_st && !bus.adc_start_n) begin
          ev[0]++;
          mux_log.push_back(bus.mux_sel);
        end
        if (prev_rd && !bus.adc_rd_n) ev[3]++;
        if (p1_valid || p2_valid)
          chk("valid_excl", 32'(p1_valid & p2_valid), 0);
        if (p1_valid) begin
          ev[1]++;
          sb_check(1'b0, p1_value);
        end
        if (p2_valid) begin
          ev[2]++;
          sb_check(1'b1, p2_value);
        end
      end
      prev_st = bus.adc_start_n;
      prev_rd = bus.adc_rd_n;
    end
  end

  initial begin : main
    int n;
    int base;
    ev = '{default: 0};
    reset = 1'b1;
    repeat (3) @(negedge sys_clk);
    reset = 1'b0;

    // Reset and idle
    @(negedge sys_clk);
    chk("rst_start_n", 32'(bus.adc_start_n), 1);
    chk("rst_rd_n", 32'(bus.adc_rd_n), 1);
    chk("rst_mux", 32'(bus.mux_sel), 0);
    chk("rst_p1", 32'(p1_value), 0);
    chk("rst_p2", 32'(p2_value), 0);
    chk("rst_valid", 32'({p1_valid, p2_valid}), 0);
    chk("rst_tmo", 32'(timeout_err), 0);
    n = 0;
    repeat (100) begin
      @(negedge sys_clk);
      if (!bus.adc_start_n) n++;
    end
    chk("idle_start", 32'(n), 0);

    // Basic alternation
    dq0.push_back(8'h3C);
    dq1.push_back(8'hC3);
    enable = 1'b1;
    wait_ev(1, 1, "t2_p1_seen");
    chk("t2_p1", 32'(p1_value), 32'h3C);
    wait_ev(2, 1, "t2_p2_seen");
    chk("t2_p2", 32'(p2_value), 32'hC3);
    no_done0 = 1'b1;
    wait_ev(0, 3, "t2_start3");
    chk("t2_mux0", 32'(mux_log[0]), 0);
    chk("t2_mux1", 32'(mux_log[1]), 1);
    chk("t2_mux2", 32'(mux_log[2]), 0);

    // Timeout on channel 0
    wait_start_high("t3_convert");
    repeat (TMO - 1) @(negedge sys_clk);
    chk("t3_tmo_early", 32'(timeout_err), 0);
    @(negedge sys_clk);
    chk("t3_tmo", 32'(timeout_err), 1);
    chk("t3_mux", 32'(bus.mux_sel), 1);
    chk("t3_no_p1", 32'(ev[1]), 1);
    no_done0 = 1'b0;
    wait_ev(2, 2, "t3_next_p2");
    chk("t3_tmo_sticky", 32'(timeout_err), 1);

    // enable drop during channel 1 conversion
    wait_ev(1, 2, "t4_p1");
    wait_ev(0, 6, "t4_start");
    wait_start_high("t4_convert");
    enable = 1'b0;
    wait_ev(2, 3, "t4_p2");
    base = ev[0];
    repeat (60) @(negedge sys_clk);
    chk("t4_nostart", 32'(ev[0]), 32'(base));
    chk("t4_mux", 32'(bus.mux_sel), 0);
    chk("t4_tmo_sticky", 32'(timeout_err), 1);

    // Async reset in READ
    enable = 1'b1;
    base = ev[3];
    wait_ev(3, base + 1, "t5_rd_seen");
    chk("t5_rd_low", 32'(bus.adc_rd_n), 0);
    #2 reset = 1'b1;
    #1;
    chk("t5_rd_n", 32'(bus.adc_rd_n), 1);
    chk("t5_start_n", 32'(bus.adc_start_n), 1);
    chk("t5_mux", 32'(bus.mux_sel), 0);
    chk("t5_p1", 32'(p1_value), 0);
    chk("t5_p2", 32'(p2_value), 0);
    chk("t5_tmo", 32'(timeout_err), 0);
    enable = 1'b0;
    repeat (3) @(negedge sys_clk);
    reset = 1'b0;

    // Two samples on channel 0
    base = ev[1];
    dq0.push_back(8'h10);
    dq0.push_back(8'h21);
    enable = 1'b1;
    wait_ev(1, base + 1, "t6_first");
    chk("t6_p1_first", 32'(p1_value), 32'h10);
    wait_ev(1, base + 2, "t6_second");
`ifdef POT_ADC_AVERAGE_EN
    chk("t6_p1_second", 32'(p1_value), 32'h19);
`else
    chk("t6_p1_second", 32'(p1_value), 32'h21);
`endif
    enable = 1'b0;
    repeat (100) @(negedge sys_clk);
    chk("sb_drain", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
